// File: rtl/drf_loader_pkg.sv
// Shared types and constants for the drf serial code loader.
// Frame: A5, LEN_H, LEN_L, N x {hi, lo}, CHK.
package drf_loader_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int         MAX_WORDS = 512;

  typedef enum logic [2:0] {
    ST_RUN,
    ST_LEN_H,
    ST_LEN_L,
    ST_DATA_HI,
    ST_DATA_LO,
    ST_CHK,
    ST_ERROR
  } ld_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  function automatic logic in_frame(input ld_state_t s);
    return s inside {ST_LEN_H, ST_LEN_L, ST_DATA_HI,
                     ST_DATA_LO, ST_CHK};
  endfunction

endpackage

// File: rtl/drf_uart_rx.sv
// 8N1 UART receiver: 2-FF synchronizer, mid-bit sampling,
// one-cycle rx_valid / rx_ferr pulses.
module drf_uart_rx
  import drf_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rx,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_ferr
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  rx_state_t     st, st_nxt;
  logic          rx_m, rx_s, rx_d;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          fall;
  logic          tick_half;
  logic          tick_bit;

  assign fall      = rx_d & ~rx_s;
  assign tick_half = (cnt == HALF_LAST);
  assign tick_bit  = (cnt == BIT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      rx_m <= uart_rx;
      rx_s <= rx_m;
      rx_d <= rx_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= RX_IDLE;
    else        st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    unique case (st)
      RX_IDLE:
        if (fall) st_nxt = RX_START;
      RX_START:
        if (tick_half)
          st_nxt = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:
        if (tick_bit && bit_idx == 3'd7)
          st_nxt = RX_STOP;
      RX_STOP:
        if (tick_bit) st_nxt = RX_IDLE;
      default:
        st_nxt = RX_IDLE;
    endcase
  end

  // cnt restarts on every state change and every sampled data bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      if (st == RX_IDLE || st_nxt != st ||
          (st == RX_DATA && tick_bit))
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;

      if (st != RX_DATA)
        bit_idx <= '0;
      else if (tick_bit)
        bit_idx <= bit_idx + 1'b1;

      if (st == RX_DATA && tick_bit)
        shift <= {rx_s, shift[7:1]};
    end
  end

  always_comb begin
    rx_valid = 1'b0;
    rx_ferr  = 1'b0;
    if (st == RX_STOP && tick_bit) begin
      rx_valid = rx_s;
      rx_ferr  = ~rx_s;
    end
  end

  assign rx_data = shift;

endmodule

// File: rtl/drf_code_loader.sv
// UART bootloader for drf_system code memory; holds the CPU
// until a checksum-verified image has been written.
module drf_code_loader
  import drf_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int TIMEOUT_CLKS = 5_000_000,
  parameter int ADDR_W       = 9,
  parameter int DATA_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              uart_rx,
  output logic              cm_we,
  output logic [ADDR_W-1:0] cm_addr,
  output logic [DATA_W-1:0] cm_data,
  output logic              cpu_run,
  output logic              busy,
  output logic              load_ok,
  output logic              load_err
);

  localparam int NW = $clog2(MAX_WORDS + 1);
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CLKS - 1);

  logic        rx_valid;
  logic        rx_ferr;
  logic [7:0]  rx_data;

  ld_state_t   st, st_nxt;
  logic [7:0]  len_h;
  logic [NW-1:0] len;
  logic [NW-1:0] wcnt;
  logic [7:0]  hi;
  logic [7:0]  sum;
  logic [TW-1:0] tmo;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] data_q;
  logic        we_q;
  logic        ok_q;

  logic [15:0] len_req;
  logic        len_bad;
  logic        last_word;
  logic [7:0]  sum_nxt;
  logic        frame;
  logic        tmo_hit;
  logic        start;

  drf_uart_rx #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx (
    .clk      (clk),
    .rst_n    (rst_n),
    .uart_rx  (uart_rx),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .rx_ferr  (rx_ferr)
  );

  assign frame     = in_frame(st);
  assign len_req   = {len_h, rx_data};
  assign len_bad   = (len_req == 16'd0) ||
                     (len_req > 16'(MAX_WORDS));
  assign last_word = ((wcnt + NW'(1)) == len);
  assign sum_nxt   = sum + rx_data;
  assign tmo_hit   = frame && !rx_valid &&
                     (tmo == TMO_LAST);
  assign start     = (st == ST_RUN || st == ST_ERROR) &&
                     rx_valid && rx_data == SYNC_BYTE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= ST_RUN;
    else        st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    unique case (st)
      ST_RUN, ST_ERROR:
        if (start) st_nxt = ST_LEN_H;
      ST_LEN_H:
        if (rx_valid) st_nxt = ST_LEN_L;
      ST_LEN_L:
        if (rx_valid)
          st_nxt = len_bad ? ST_ERROR : ST_DATA_HI;
      ST_DATA_HI:
        if (rx_valid) st_nxt = ST_DATA_LO;
      ST_DATA_LO:
        if (rx_valid)
          st_nxt = last_word ? ST_CHK : ST_DATA_HI;
      ST_CHK:
        if (rx_valid)
          st_nxt = (sum_nxt == 8'h00) ? ST_RUN : ST_ERROR;
      default:
        st_nxt = ST_ERROR;
    endcase
    if (frame && (rx_ferr || tmo_hit))
      st_nxt = ST_ERROR;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_h  <= '0;
      len    <= '0;
      wcnt   <= '0;
      hi     <= '0;
      sum    <= '0;
      tmo    <= '0;
      waddr  <= '0;
      data_q <= '0;
      we_q   <= 1'b0;
      ok_q   <= 1'b0;
    end else begin
      we_q <= 1'b0;
      ok_q <= 1'b0;

      if (!frame || rx_valid) tmo <= '0;
      else                    tmo <= tmo + 1'b1;

      if (start) begin
        sum   <= '0;
        wcnt  <= '0;
        waddr <= '0;
      end else if (frame && rx_valid) begin
        sum <= sum_nxt;
      end

      if (st == ST_LEN_H && rx_valid)
        len_h <= rx_data;
      if (st == ST_LEN_L && rx_valid)
        len <= len_req[NW-1:0];
      if (st == ST_DATA_HI && rx_valid)
        hi <= rx_data;

      if (st == ST_DATA_LO && rx_valid) begin
        we_q   <= 1'b1;
        data_q <= DATA_W'({hi, rx_data});
      end

      // address advances once the strobe for this word has gone out
      if (we_q) begin
        waddr <= waddr + 1'b1;
        wcnt  <= wcnt + 1'b1;
      end

      if (st == ST_CHK && st_nxt == ST_RUN)
        ok_q <= 1'b1;
    end
  end

  always_comb begin
    cpu_run  = 1'b0;
    busy     = 1'b0;
    load_err = 1'b0;
    unique case (1'b1)
      st == ST_RUN:   cpu_run  = 1'b1;
      st == ST_ERROR: load_err = 1'b1;
      default:        busy     = 1'b1;
    endcase
  end

  assign cm_we   = we_q;
  assign cm_addr = waddr;
  assign cm_data = data_q;
  assign load_ok = ok_q;

endmodule

// File: tb/tb_drf_code_loader.sv
// Randomised self-checking bench for drf_code_loader with a
// frame-level reference model.
module tb_drf_code_loader;

  localparam int CPB = 8;
  localparam int TMO = 400;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        uart_rx = 1'b1;
  logic        cm_we;
  logic [8:0]  cm_addr;
  logic [15:0] cm_data;
  logic        cpu_run;
  logic        busy;
  logic        load_ok;
  logic        load_err;

  int errors = 0;
  int checks = 0;
  int ok_cnt = 0;
  logic [24:0] got_q[$];
  logic [24:0] exp_q[$];

  drf_code_loader #(
    .CLKS_PER_BIT (CPB),
    .TIMEOUT_CLKS (TMO),
    .ADDR_W       (9),
    .DATA_W       (16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .uart_rx  (uart_rx),
    .cm_we    (cm_we),
    .cm_addr  (cm_addr),
    .cm_data  (cm_data),
    .cpu_run  (cpu_run),
    .busy     (busy),
    .load_ok  (load_ok),
    .load_err (load_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cm_we) got_q.push_back({cm_addr, cm_data});
    if (load_ok) ok_cnt++;
  end

  task automatic send_byte(input logic [7:0] b,
                           input logic stop);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = stop;
    repeat (CPB) @(negedge clk);
    uart_rx = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic send_frame(input bq_t f);
    foreach (f[i]) send_byte(f[i], 1'b1);
    repeat (6) @(negedge clk);
  endtask

  task automatic clear_obs();
    got_q.delete();
    ok_cnt = 0;
  endtask

  task automatic do_reset();
    uart_rx = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    clear_obs();
  endtask

  // Frame-level model: words land at consecutive addresses from 0
  // if the length is legal; success iff LEN_H..CHK sums to 0 mod 256.
  task automatic model_frame(input bq_t b, output logic ok,
                             output logic err);
    int n;
    int s;
    exp_q.delete();
    ok = 1'b0;
    err = 1'b1;
    n = b[1] * 256 + b[2];
    if (n == 0 || n > 512) return;
    for (int i = 0; i < n; i++)
      exp_q.push_back({9'(i), b[3 + 2 * i], b[4 + 2 * i]});
    s = 0;
    for (int j = 1; j < b.size(); j++) s += b[j];
    ok = (s % 256) == 0;
    err = !ok;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({cpu_run, busy, cm_we, load_err, load_ok} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 10000",
               {cpu_run, busy, cm_we, load_err, load_ok});
    end
    checks++;
    if ({cm_addr, cm_data} !== 25'd0) begin
      errors++;
      $display("FAIL reset_bus: got %h expected 0",
               {cm_addr, cm_data});
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    clear_obs();
    send_byte(8'h5A, 1'b1);
    repeat (6) @(negedge clk);
    checks++;
    if ({cpu_run, busy, load_err, ok_cnt != 0, got_q.size() != 0}
        !== 5'b10000) begin
      errors++;
      $display("FAIL noise_byte: got %b expected 10000",
               {cpu_run, busy, load_err, ok_cnt != 0,
                got_q.size() != 0});
    end
  endtask

  task automatic test_good_frame();
    bq_t f;
    logic eok, eerr;
    logic busy_low;
    f = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34,
          8'hAB, 8'hCD, 8'h40};
    clear_obs();
    busy_low = 1'b0;
    for (int i = 0; i < f.size(); i++) begin
      send_byte(f[i], 1'b1);
      if (i < f.size() - 1 && (!busy || cpu_run)) busy_low = 1'b1;
    end
    repeat (6) @(negedge clk);
    model_frame(f, eok, eerr);
    checks++;
    if (busy_low !== 1'b0) begin
      errors++;
      $display("FAIL good_busy: got dropped expected held high");
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL good_nwrites: got %0d expected %0d",
               got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL good_write[%0d]: got %h expected %h",
                 i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (ok_cnt != 1 || eok !== 1'b1) begin
      errors++;
      $display("FAIL good_load_ok: got %0d pulses expected 1",
               ok_cnt);
    end
    checks++;
    if ({cpu_run, busy, load_err} !== 3'b100) begin
      errors++;
      $display("FAIL good_end: got %b expected 100",
               {cpu_run, busy, load_err});
    end
  endtask

  task automatic test_bad_chk();
    bq_t f;
    logic eok, eerr;
    f = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34,
          8'hAB, 8'hCD, 8'h41};
    clear_obs();
    send_frame(f);
    model_frame(f, eok, eerr);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL badchk_nwrites: got %0d expected %0d",
               got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL badchk_write[%0d]: got %h expected %h",
                 i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if ({cpu_run, busy, load_err, ok_cnt != 0} !==
        {eok, 1'b0, eerr, 1'b0}) begin
      errors++;
      $display("FAIL badchk_end: got %b expected %b",
               {cpu_run, busy, load_err, ok_cnt != 0},
               {eok, 1'b0, eerr, 1'b0});
    end
    f[7] = 8'h40;
    clear_obs();
    send_frame(f);
    checks++;
    if ({cpu_run, load_err, ok_cnt == 1} !== 3'b101) begin
      errors++;
      $display("FAIL badchk_recover: got %b expected 101",
               {cpu_run, load_err, ok_cnt == 1});
    end
  endtask

  task automatic test_bad_len();
    clear_obs();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h01, 1'b1);
    repeat (4) @(negedge clk);
    checks++;
    if ({load_err, busy, cpu_run, got_q.size() != 0} !== 4'b1000) begin
      errors++;
      $display("FAIL len513: got %b expected 1000",
               {load_err, busy, cpu_run, got_q.size() != 0});
    end
  endtask

  task automatic test_timeout();
    clear_obs();
    send_byte(8'hA5, 1'b1);
    checks++;
    if ({busy, load_err} !== 2'b10) begin
      errors++;
      $display("FAIL tmo_restart: got %b expected 10",
               {busy, load_err});
    end
    send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h12, 1'b1);
    repeat (TMO - 100) @(negedge clk);
    checks++;
    if ({busy, load_err} !== 2'b10) begin
      errors++;
      $display("FAIL tmo_early: got %b expected 10",
               {busy, load_err});
    end
    repeat (150) @(negedge clk);
    checks++;
    if ({load_err, busy, cpu_run, got_q.size() != 0} !== 4'b1000) begin
      errors++;
      $display("FAIL tmo_expire: got %b expected 1000",
               {load_err, busy, cpu_run, got_q.size() != 0});
    end
  endtask

  task automatic test_ferr();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    checks++;
    if ({busy, load_err} !== 2'b10) begin
      errors++;
      $display("FAIL ferr_pre: got %b expected 10", {busy, load_err});
    end
    send_byte(8'h01, 1'b0);
    repeat (4) @(negedge clk);
    checks++;
    if ({load_err, busy, cpu_run} !== 3'b100) begin
      errors++;
      $display("FAIL ferr: got %b expected 100",
               {load_err, busy, cpu_run});
    end
  endtask

  task automatic test_glitch();
    bq_t f;
    do_reset();
    uart_rx = 1'b0;
    repeat (2) @(negedge clk);
    uart_rx = 1'b1;
    repeat (40) @(negedge clk);
    checks++;
    if ({cpu_run, busy, load_err, got_q.size() != 0} !== 4'b1000) begin
      errors++;
      $display("FAIL glitch: got %b expected 1000",
               {cpu_run, busy, load_err, got_q.size() != 0});
    end
    f = '{8'hA5, 8'h00, 8'h01, 8'hC3, 8'h3C, 8'h00};
    send_frame(f);
    checks++;
    if ({cpu_run, ok_cnt == 1, got_q.size() == 1} !== 3'b111) begin
      errors++;
      $display("FAIL glitch_after: got %b expected 111",
               {cpu_run, ok_cnt == 1, got_q.size() == 1});
    end
  endtask

  task automatic test_reset_mid();
    clear_obs();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    send_byte(8'h56, 1'b1);
    checks++;
    if ({cm_addr, busy, got_q.size() == 1} !== {9'd1, 2'b11}) begin
      errors++;
      $display("FAIL mid_pre: got %h expected %h",
               {cm_addr, busy, got_q.size() == 1}, {9'd1, 2'b11});
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({cpu_run, busy, cm_we, load_err, load_ok, cm_addr, cm_data}
        !== {5'b10000, 25'd0}) begin
      errors++;
      $display("FAIL mid_reset: got %h expected %h",
               {cpu_run, busy, cm_we, load_err, load_ok, cm_addr,
                cm_data}, {5'b10000, 25'd0});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_random();
    bq_t f;
    logic eok, eerr;
    int n;
    logic [7:0] s;
    logic [7:0] nb;
    logic [15:0] w;
    for (int k = 0; k < 8; k++) begin
      n = $urandom_range(1, 6);
      f = '{8'hA5, 8'(n >> 8), 8'(n)};
      s = f[1] + f[2];
      for (int i = 0; i < n; i++) begin
        w = 16'($urandom);
        f.push_back(w[15:8]);
        f.push_back(w[7:0]);
        s += w[15:8] + w[7:0];
      end
      s = 8'h00 - s;
      if ($urandom_range(0, 2) == 0)
        s += 8'($urandom_range(1, 255));
      f.push_back(s);
      nb = 8'($urandom);
      if (nb == 8'hA5) nb = 8'h5A;
      clear_obs();
      send_byte(nb, 1'b1);
      send_frame(f);
      model_frame(f, eok, eerr);
      checks++;
      if (got_q.size() != exp_q.size()) begin
        errors++;
        $display("FAIL rnd%0d_nwrites: got %0d expected %0d",
                 k, got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL rnd%0d_write[%0d]: got %h expected %h",
                   k, i, got_q[i], exp_q[i]);
        end
      end
      checks++;
      if ({cpu_run, busy, load_err, ok_cnt} !==
          {eok, 1'b0, eerr, 32'(eok)}) begin
        errors++;
        $display("FAIL rnd%0d_end: run/busy/err=%b ok=%0d expected %b ok=%0d",
                 k, {cpu_run, busy, load_err}, ok_cnt,
                 {eok, 1'b0, eerr}, eok);
      end
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_chk();
    test_bad_len();
    test_timeout();
    test_ferr();
    test_glitch();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/drf_code_loader.md
Name: drf_code_loader

Overview:
- Serial bootloader upstream of drf_system's code memory: receives a program image over a UART line, writes it word-by-word into the 512x16 code memory, and gates CPU execution.
- While a load is in progress `cpu_run` is low, so the system holds its PC/IR sequencing. `cpu_run` releases only after a checksum-verified image.
- Sits between the board UART pin and the code memory write port.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200); minimum 4.
- TIMEOUT_CLKS, 5_000_000, maximum idle clk cycles between bytes inside a frame.
- ADDR_W, 9, code memory address width (matches PC width).
- DATA_W, 16, code memory word width (matches instruction width).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- uart_rx  in  1  serial input; idle high; 8N1, LSB first.
- cm_we  out  1  code memory write strobe, one-cycle pulse per word.
- cm_addr  out  ADDR_W  code memory write address.
- cm_data  out  DATA_W  code memory write data.
- cpu_run  out  1  high = CPU may execute; low = hold system.
- busy  out  1  high while a frame is being received.
- load_ok  out  1  one-cycle pulse on a successful load.
- load_err  out  1  sticky error flag.

Behaviour:
- Reset: asynchronous and active-low; affects all state.
  - Outputs reset to cpu_run=1 (run the resident image), busy=0, cm_we=0, cm_addr=0, cm_data=0, load_ok=0, load_err=0.
  - UART receiver returns to idle.
- Reset mid-load: the load is abandoned immediately; already-written words remain in code memory, and the host must reload.
- UART receiver:
  - uart_rx passes through a 2-FF synchronizer.
  - Falling edge starts a bit timer; the line is re-sampled at CLKS_PER_BIT/2. If it is high, this is a glitch: return to idle with no output.
  - 8 data bits are sampled every CLKS_PER_BIT, LSB first, then the stop bit.
  - Stop=1: rx_valid pulses one cycle with rx_data. Stop=0: rx_ferr pulses one cycle instead.
- Frame format: 0xA5 sync, LEN_H, LEN_L, then N words (hi byte, lo byte), then CHK.
  - N = {LEN_H, LEN_L}, valid range 1..512.
  - CHK makes the 8-bit sum of all bytes from LEN_H through CHK equal 0x00. The sync byte is excluded.
- FSM states: RUN, LEN_H, LEN_L, DATA_HI, DATA_LO, CHK, ERROR.
  - RUN: rx byte 0xA5 -> LEN_H, with cpu_run<=0, busy<=1, cm_addr<=0, sum<=0. Any other byte is ignored. Frame errors are ignored.
  - LEN_H -> LEN_L.
  - LEN_L: N=0 or N>512 -> ERROR; otherwise -> DATA_HI.
  - DATA_HI: latch the hi byte -> DATA_LO.
  - DATA_LO: the cycle after rx_valid, drive cm_we=1, cm_data={hi,lo}, cm_addr=word index.
    - Word index (cm_addr) increments after each write, so the first word goes to address 0.
    - After N words -> CHK; otherwise -> DATA_HI.
  - CHK: if the sum is 0x00, the next cycle drives cpu_run=1, busy=0, load_ok pulse, and the FSM returns to RUN. Otherwise -> ERROR.
  - Any in-frame state (LEN_H..CHK): rx_ferr -> ERROR. If the idle counter reaches TIMEOUT_CLKS with no rx_valid -> ERROR. The counter reloads on every rx_valid.
  - ERROR: load_err=1, busy=0, cpu_run=0 (the image is untrusted). A byte 0xA5 restarts the load, clears load_err, and enters LEN_H. Other bytes are ignored.
- The running 8-bit sum wraps modulo 256.
- cm_we is never asserted outside DATA_LO, and at most one cycle per word.

Decomposition:
- Shared package drf_loader_pkg: SYNC_BYTE=8'hA5, MAX_WORDS=512, FSM state enum.
- Sub-module drf_uart_rx: synchronizer, bit timer, and shift register. It outputs rx_valid, rx_data[7:0], and rx_ferr.
- The loader FSM, sum accumulator, and timeout counter live in drf_code_loader.

Test Plan (bench uses CLKS_PER_BIT=8, TIMEOUT_CLKS=400):
- Reset release -> cpu_run=1, busy=0, cm_we=0, load_err=0. Send byte 0x5A -> no output change.
- Send A5 00 02 12 34 AB CD 40 -> cm_we pulses {addr 0, data 0x1234} then {addr 1, data 0xABCD}; the cycle after CHK gives one load_ok pulse; cpu_run returns to 1; busy was high from sync to CHK.
- Same frame with CHK=0x41 -> both words written, then load_err=1, cpu_run=0, no load_ok. A subsequent valid frame clears load_err and ends with cpu_run=1.
- Send A5 02 01 (N=513) -> ERROR right after LEN_L; no cm_we; load_err=1.
- Send A5 00 01 12, then silence for 400 clks -> load_err=1. Separately, send a byte with stop bit 0 inside a frame -> load_err=1.
- Start-bit glitch of 2 clks in RUN -> ignored. Assert rst_n low mid-DATA_LO -> outputs immediately at reset values with cpu_run=1.
